// File: rtl/byte_joining_param_if.sv
// Lane-set input and byte-stream output bundle for the byte joiner.
// master drives lane sets and out_ready; slave is the joiner itself.
interface byte_joining_param_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    logic [NUM_LANES*WIDTH-1:0] lane_data;
    logic                       lane_valid;
    logic [CNT_W:0]             active_lanes;
    logic                       in_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       overrun;

    modport master (
        output lane_data, lane_valid, active_lanes, out_ready,
        input  in_ready, out_data, out_valid, out_last, overrun
    );

    modport slave (
        input  lane_data, lane_valid, active_lanes, out_ready,
        output in_ready, out_data, out_valid, out_last, overrun
    );
endinterface

// File: rtl/byte_joining_param.sv
// Joins NUM_LANES aligned lane words into one byte stream, lane 0 first,
// with a runtime lane count, last marker and sticky overrun flag.
module byte_joining_param #(
    parameter int WIDTH     = 8,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    byte_joining_param_if.slave  bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] NL  = (CNT_W+1)'(NUM_LANES);

    state_t                     state_q, state_d;
    logic [NUM_LANES*WIDTH-1:0] hold_q;
    logic [CNT_W-1:0]           idx_q;
    logic [CNT_W:0]             n_act_q;
    logic                       overrun_q;

    logic [CNT_W:0] n_clamp;
    logic           last_idx;
    logic           in_ready;
    logic           capture;
    logic           advance;

    assign last_idx = ({1'b0, idx_q} == (n_act_q - ONE));
    assign capture  = bus.lane_valid && in_ready;
    assign advance  = (state_q == SEND) && bus.out_ready && !last_idx;

    always_comb begin
        n_clamp = bus.active_lanes;
        if (bus.active_lanes == '0)
            n_clamp = ONE;
        else if (bus.active_lanes > NL)
            n_clamp = NL;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A completing set with a new set waiting re-enters SEND with no bubble
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (capture) state_d = SEND;
            SEND: if (bus.out_ready && last_idx)
                      state_d = capture ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == IDLE) ||
                       ((state_q == SEND) && last_idx && bus.out_ready);
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == SEND);
        bus.out_last  = (state_q == SEND) && last_idx;
        bus.out_data  = '0;
        if (state_q == SEND)
            bus.out_data = hold_q[int'(idx_q)*WIDTH +: WIDTH];
        bus.overrun   = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            idx_q     <= '0;
            n_act_q   <= NL;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                hold_q  <= bus.lane_data;
                n_act_q <= n_clamp;
                idx_q   <= '0;
            end else if (advance) begin
                idx_q   <= idx_q + CNT_W'(1);
            end
            if (bus.lane_valid && !in_ready)
                overrun_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_byte_joining_param.sv
// Directed scoreboard bench for byte_joining_param (4 lanes x 8 bits).
// Expected bytes are queued at drive time and popped on each transfer.
module tb_byte_joining_param;
    localparam int WIDTH = 8;
    localparam int NL    = 4;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    byte_joining_param_if #(.WIDTH(WIDTH), .NUM_LANES(NL)) bus ();

    byte_joining_param #(.WIDTH(WIDTH), .NUM_LANES(NL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int clamp(int al);
        if (al == 0) return 1;
        if (al > NL) return NL;
        return al;
    endfunction

    task automatic push_set(logic [31:0] data, int al);
        int n;
        n = clamp(al);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n-1), data[i*8 +: 8]});
    endtask

    // Drive one lane set for a single cycle; caller guarantees in_ready
    task automatic send(logic [31:0] data, int al);
        chk("in_ready_before_send", bus.in_ready, 1);
        bus.lane_data    = data;
        bus.active_lanes = 3'(al);
        bus.lane_valid   = 1'b1;
        push_set(data, al);
        @(posedge clk); #1;
        bus.lane_valid   = 1'b0;
    endtask

    task automatic drain(string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, bus.out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                logic [8:0] e;
                chk("exp_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[7:0]);
                    chk("out_last", bus.out_last, e[8]);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic [5:0] pat;
        reset            = 1'b1;
        bus.lane_data    = '0;
        bus.lane_valid   = 1'b0;
        bus.active_lanes = 3'd4;
        bus.out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_overrun", bus.overrun, 0);
        reset = 1'b0;

        send(32'h44332211, 4);
        chk("latency_valid", bus.out_valid, 1);
        chk("latency_data", bus.out_data, 8'h11);
        drain("full");

        send(32'h44332211, 2);
        drain("two");
        send(32'h44332211, 0);
        chk("single_last", bus.out_last, 1);
        drain("zero");
        send(32'h44332211, 7);
        drain("seven");

        // out_ready sequence 1,0,0,1,1,1 applied LSB first
        pat = 6'b111001;
        send(32'h44332211, 4);
        for (int k = 0; k < 6; k++) begin
            bus.out_ready = pat[k];
            #1;
            chk($sformatf("bp_in_ready_%0d", k), bus.in_ready, (k == 5));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        chk("bp_count", exp_q.size(), 0);
        chk("bp_idle", bus.out_valid, 0);

        send(32'h44332211, 4);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("b2b_last_shown", bus.out_data, 8'h44);
        send(32'hDDCCBBAA, 4);
        chk("b2b_no_bubble_valid", bus.out_valid, 1);
        chk("b2b_no_bubble_data", bus.out_data, 8'hAA);
        drain("b2b");
        chk("b2b_no_overrun", bus.overrun, 0);

        send(32'h44332211, 4);
        @(posedge clk); #1;
        bus.lane_data  = 32'h99887766;
        bus.lane_valid = 1'b1;
        @(posedge clk); #1;
        bus.lane_valid = 1'b0;
        chk("overrun_set", bus.overrun, 1);
        drain("overrun");
        chk("overrun_sticky", bus.overrun, 1);

        send(32'h44332211, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_idx2", bus.out_data, 8'h33);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_overrun", bus.overrun, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst_stays_idle", bus.out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
